// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operation codes, FSM state enum and the registered control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  // br marks the branch state, whose PC write is qualified by zero downstream.
  typedef struct packed {
    logic       pc_we;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       br;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_t st, logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01;
        c.alu_op = ALU_ADD; c.pc_we = 1'b1;
      end
      S_DECODE:    begin c.alu_src_b = 2'b11; c.alu_op = ALU_ADD; end
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = op; end
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_I_EXEC:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = op; end
      S_I_WB:      c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'b10; c.br = 1'b1;
      end
      S_JUMP:      begin c.pc_src = 2'b01; c.pc_we = 1'b1; end
      S_JAL:       begin c.pc_src = 2'b01; c.pc_we = 1'b1; c.reg_write = 1'b1; end
      S_JR:        c.pc_we = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_controller_alu_control.sv
// Funct field to ALU operation decode; func_ok is set only for the R-type
// arithmetic/logic functs (jr is resolved by the controller itself).
module alu_control
  import mips_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       func_ok
);

  always_comb begin
    alu_op  = ALU_ADD;
    func_ok = 1'b1;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: func_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multi-cycle MIPS control FSM. Control bits are registered alongside the state;
// MIPS_LINK_EN adds jal/jr (JAL and JR states, sel31/selPc/Jrsel).
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPC,
  input  logic [5:0] Func,
  input  logic       zero,
  output logic       PCsel,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       sel31,
  output logic       MemToReg,
  output logic       selPc,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_operation,
  output logic [1:0] PCSrc,
  output logic       Jrsel,
  output logic       illegal
);

  state_t     state, nxt;
  ctrl_t      ctrl_q;
  logic [2:0] r_op, nxt_op;
  logic       r_ok, is_sw, nxt_sw, legal, en;

  alu_control u_alu_control (
    .func    (Func),
    .alu_op  (r_op),
    .func_ok (r_ok)
  );

  // OPC/Func are only trusted in DECODE; later states steer from registered flags.
  always_comb begin
    nxt    = S_FETCH;
    nxt_op = ALU_ADD;
    nxt_sw = is_sw;
    legal  = 1'b1;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (OPC)
          OP_RTYPE: begin
            if (r_ok) begin
              nxt    = S_R_EXEC;
              nxt_op = r_op;
            end
`ifdef MIPS_LINK_EN
            else if (Func == FN_JR) nxt = S_JR;
`endif
            else legal = 1'b0;
          end
          OP_LW:   begin nxt = S_MEM_ADDR; nxt_sw = 1'b0; end
          OP_SW:   begin nxt = S_MEM_ADDR; nxt_sw = 1'b1; end
          OP_BEQ:  nxt = S_BRANCH;
          OP_ADDI: begin nxt = S_I_EXEC; nxt_op = ALU_ADD; end
          OP_SLTI: begin nxt = S_I_EXEC; nxt_op = ALU_SLT; end
          OP_J:    nxt = S_JUMP;
`ifdef MIPS_LINK_EN
          OP_JAL:  nxt = S_JAL;
`endif
          default: legal = 1'b0;
        endcase
      end
      S_MEM_ADDR: nxt = is_sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: nxt = S_MEM_WB;
      S_R_EXEC:   nxt = S_R_WB;
      S_I_EXEC:   nxt = S_I_WB;
      default:    nxt = S_FETCH;
    endcase
  end

`ifdef MIPS_LINK_EN
  logic sel31_q, selpc_q, jrsel_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      ctrl_q <= ctrl_for(S_FETCH, ALU_ADD);
      is_sw  <= 1'b0;
`ifdef MIPS_LINK_EN
      sel31_q <= 1'b0;
      selpc_q <= 1'b0;
      jrsel_q <= 1'b0;
`endif
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_for(nxt, nxt_op);
      is_sw  <= nxt_sw;
`ifdef MIPS_LINK_EN
      sel31_q <= (nxt == S_JAL);
      selpc_q <= (nxt == S_JAL);
      jrsel_q <= (nxt == S_JR);
`endif
    end
  end

  // Reset blanks every output, including the cycle it is raised mid-instruction.
  assign en            = ~rst;
  assign PCsel         = en & (ctrl_q.pc_we | (ctrl_q.br & zero));
  assign IorD          = en & ctrl_q.iord;
  assign MemRead       = en & ctrl_q.mem_read;
  assign MemWrite      = en & ctrl_q.mem_write;
  assign IRWrite       = en & ctrl_q.ir_write;
  assign RegDst        = en & ctrl_q.reg_dst;
  assign MemToReg      = en & ctrl_q.mem_to_reg;
  assign RegWrite      = en & ctrl_q.reg_write;
  assign ALUSrcA       = en & ctrl_q.alu_src_a;
  assign ALUSrcB       = en ? ctrl_q.alu_src_b : 2'b00;
  assign ALU_operation = en ? ctrl_q.alu_op : 3'b000;
  assign PCSrc         = en ? ctrl_q.pc_src : 2'b00;
  assign illegal       = en & (state == S_DECODE) & ~legal;

`ifdef MIPS_LINK_EN
  assign sel31 = en & sel31_q;
  assign selPc = en & selpc_q;
  assign Jrsel = en & jrsel_q;
`else
  assign sel31 = 1'b0;
  assign selPc = 1'b0;
  assign Jrsel = 1'b0;
`endif

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: the driver expands each instruction into
// its spec-level step list and queues expected outputs; a monitor compares.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] OPC = '0, Func = '0;
  logic       zero = 1'b0;
  logic       PCsel, IorD, MemRead, MemWrite, IRWrite, RegDst, sel31, MemToReg;
  logic       selPc, RegWrite, ALUSrcA, Jrsel, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALU_operation;

`ifdef MIPS_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  mips_controller dut (
    .clk(clk), .rst(rst), .OPC(OPC), .Func(Func), .zero(zero),
    .PCsel(PCsel), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .sel31(sel31), .MemToReg(MemToReg),
    .selPc(selPc), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_operation(ALU_operation), .PCSrc(PCSrc), .Jrsel(Jrsel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit pcsel, iord, mr, mw, irw, regdst, sel31, m2r, selpc, rw, srca;
    bit [1:0] srcb;
    bit [2:0] op;
    bit [1:0] pcsrc;
    bit jrsel, ill;
  } exp_t;

  typedef enum int {K_RST, K_FETCH, K_DEC, K_MADDR, K_MRD, K_MWB, K_MWR,
                    K_REX, K_RWB, K_IEX, K_IWB, K_BR, K_J, K_JAL, K_JR} kind_t;

  typedef struct { exp_t e; kind_t k; int cyc; } sb_t;

  sb_t sb[$];
  int  total = 0, bad = 0, cyc = 0;

  // Expected outputs of each step, straight from the state behaviour table.
  function automatic exp_t expect_of(kind_t k, bit [2:0] op, bit z, bit ill);
    exp_t e = '0;
    case (k)
      K_FETCH: begin e.mr = 1; e.irw = 1; e.srcb = 2'b01; e.op = 3'b010; e.pcsel = 1; end
      K_DEC:   begin e.srcb = 2'b11; e.op = 3'b010; e.ill = ill; end
      K_MADDR: begin e.srca = 1; e.srcb = 2'b10; e.op = 3'b010; end
      K_MRD:   begin e.mr = 1; e.iord = 1; end
      K_MWB:   begin e.rw = 1; e.m2r = 1; end
      K_MWR:   begin e.mw = 1; e.iord = 1; end
      K_REX:   begin e.srca = 1; e.op = op; end
      K_RWB:   begin e.rw = 1; e.regdst = 1; end
      K_IEX:   begin e.srca = 1; e.srcb = 2'b10; e.op = op; end
      K_IWB:   e.rw = 1;
      K_BR:    begin e.srca = 1; e.op = 3'b110; e.pcsrc = 2'b10; e.pcsel = z; end
      K_J:     begin e.pcsrc = 2'b01; e.pcsel = 1; end
      K_JAL:   begin e.pcsrc = 2'b01; e.pcsel = 1; e.rw = 1; e.sel31 = 1; e.selpc = 1; end
      K_JR:    begin e.jrsel = 1; e.pcsel = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Instruction -> sequence of steps, ALU op for the exec step, and legality.
  task automatic plan(input bit [5:0] opc, input bit [5:0] fn,
                      output kind_t ks[$], output bit [2:0] op, output bit ill);
    ks = {K_FETCH, K_DEC};
    op = 3'b010;
    ill = 0;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000: op = 3'b010;
          6'b100010: op = 3'b110;
          6'b100100: op = 3'b000;
          6'b100101: op = 3'b001;
          6'b101010: op = 3'b111;
          default:   ill = 1;
        endcase
        if (!ill) begin ks.push_back(K_REX); ks.push_back(K_RWB); end
        else if (fn == 6'b001000 && LINK) begin ill = 0; ks.push_back(K_JR); end
      end
      6'b100011: begin ks.push_back(K_MADDR); ks.push_back(K_MRD); ks.push_back(K_MWB); end
      6'b101011: begin ks.push_back(K_MADDR); ks.push_back(K_MWR); end
      6'b000100: ks.push_back(K_BR);
      6'b001000: begin op = 3'b010; ks.push_back(K_IEX); ks.push_back(K_IWB); end
      6'b001010: begin op = 3'b111; ks.push_back(K_IEX); ks.push_back(K_IWB); end
      6'b000010: ks.push_back(K_J);
      6'b000011: if (LINK) ks.push_back(K_JAL); else ill = 1;
      default:   ill = 1;
    endcase
  endtask

  task automatic push(input exp_t e, input kind_t k);
    sb_t s;
    s.e = e; s.k = k; s.cyc = cyc;
    sb.push_back(s);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      rst = 1'b1;
      zero = 1'($urandom);
      OPC = 6'($urandom);
      Func = 6'($urandom);
      push('0, K_RST);
    end
  endtask

  // zf: -1 random zero, else forced. abort: step index at which rst is raised.
  task automatic run_instr(input bit [5:0] opc, input bit [5:0] fn,
                           input int zf, input int abort);
    kind_t  ks[$];
    bit [2:0] op;
    bit     ill;
    plan(opc, fn, ks, op, ill);
    for (int i = 0; i <= ks.size(); i++) begin
      if (i == abort) begin
        reset_cycles(1);
        return;
      end
      if (i == ks.size()) return;
      @(posedge clk); #1;
      cyc++;
      rst  = 1'b0;
      zero = (zf < 0) ? 1'($urandom) : 1'(zf);
      OPC  = (ks[i] == K_DEC) ? opc : 6'($urandom);
      Func = (ks[i] == K_DEC) ? fn  : 6'($urandom);
      push(expect_of(ks[i], op, zero, ill && ks[i] == K_DEC), ks[i]);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t  s;
      exp_t a;
      s = sb.pop_front();
      a = {PCsel, IorD, MemRead, MemWrite, IRWrite, RegDst, sel31, MemToReg, selPc,
           RegWrite, ALUSrcA, ALUSrcB, ALU_operation, PCSrc, Jrsel, illegal};
      total++;
      if (a !== s.e) begin
        bad++;
        $display("FAIL step %s cyc %0d: got %05h want %05h", s.k.name(), s.cyc, a, s.e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  localparam bit [5:0] LEGAL_OPC [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                         6'b001000, 6'b001010, 6'b000010, 6'b000011};
  localparam bit [5:0] LEGAL_FN  [6] = '{6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b101010, 6'b001000};

  initial begin
    reset_cycles(3);
    run_instr(6'b100011, 6'h00, -1, -1);          // lw
    run_instr(6'b000100, 6'h00, 1, -1);           // beq taken
    run_instr(6'b000100, 6'h00, 0, -1);           // beq not taken
    run_instr(6'b000000, 6'b100010, -1, -1);      // sub
    run_instr(6'b000000, 6'b101010, -1, -1);      // slt
    run_instr(6'b000011, 6'h00, -1, -1);          // jal
    run_instr(6'b000000, 6'b001000, -1, -1);      // jr
    run_instr(6'b101011, 6'h00, -1, -1);          // sw
    run_instr(6'b111111, 6'h00, -1, 2);           // illegal, then reset in FETCH
    run_instr(6'b100011, 6'h00, -1, 3);           // lw aborted in MEM_READ
    run_instr(6'b001010, 6'h00, -1, -1);          // slti
    for (int n = 0; n < 300; n++) begin
      bit [5:0] o, f;
      int ab;
      o = ($urandom_range(0, 9) < 8) ? LEGAL_OPC[$urandom_range(0, 7)] : 6'($urandom);
      f = ($urandom_range(0, 9) < 8) ? LEGAL_FN[$urandom_range(0, 5)] : 6'($urandom);
      ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(o, f, -1, ab);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
